// File: rtl/store_broadcast_arbiter_if.sv
// Store exchange bundle between two rv32i cores and the broadcast arbiter.
// The master drives the core-side store ports. The slave (the arbiter) drives the external write ports.
interface store_broadcast_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             wrenInC0;
    logic [31:0]      addrInC0;
    logic [31:0]      dataInC0;
    logic [2:0]       funct3InC0;
    logic             wrenInC1;
    logic [31:0]      addrInC1;
    logic [31:0]      dataInC1;
    logic [2:0]       funct3InC1;

    logic             wrenOutC0;
    logic [31:0]      addrOutC0;
    logic [31:0]      dataOutC0;
    logic [2:0]       funct3OutC0;
    logic             wrenOutC1;
    logic [31:0]      addrOutC1;
    logic [31:0]      dataOutC1;
    logic [2:0]       funct3OutC1;

    logic             extStall;
    logic [CNT_W-1:0] collisionCount;

    modport master (
        output wrenInC0, addrInC0, dataInC0, funct3InC0,
        output wrenInC1, addrInC1, dataInC1, funct3InC1,
        input  wrenOutC0, addrOutC0, dataOutC0, funct3OutC0,
        input  wrenOutC1, addrOutC1, dataOutC1, funct3OutC1,
        input  extStall, collisionCount
    );

    modport slave (
        input  wrenInC0, addrInC0, dataInC0, funct3InC0,
        input  wrenInC1, addrInC1, dataInC1, funct3InC1,
        output wrenOutC0, addrOutC0, dataOutC0, funct3OutC0,
        output wrenOutC1, addrOutC1, dataOutC1, funct3OutC1,
        output extStall, collisionCount
    );
endinterface

// File: rtl/store_broadcast_arbiter.sv
// Buffers each core's stores and round-robin broadcasts one per cycle to the other core's write port.
// Latency is 2 edges from push to Out. extStall is raised while either FIFO is full.
module store_broadcast_arbiter #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    store_broadcast_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct3;
    } store_t;

    store_t           mem0 [DEPTH];
    store_t           mem1 [DEPTH];
    logic [PW-1:0]    head0, head1, tail0, tail1;
    logic [CW-1:0]    cnt0, cnt1;
    logic             rr_ptr;
    logic [CNT_W-1:0] coll_cnt;

    store_t           out0, out1;
    logic             wren0, wren1;

    logic full0, full1, vld0, vld1;
    logic grant0, grant1, acc0, acc1;
    store_t in0, in1;

    always_comb begin
        full0  = (cnt0 == CW'(DEPTH));
        full1  = (cnt1 == CW'(DEPTH));
        vld0   = (cnt0 != '0);
        vld1   = (cnt1 != '0);
        grant0 = vld0 & (~vld1 | ~rr_ptr);
        grant1 = vld1 & (~vld0 |  rr_ptr);
        // A full FIFO popping this edge frees its slot in time to take the new store.
        acc0   = bus.wrenInC0 & (~full0 | grant0);
        acc1   = bus.wrenInC1 & (~full1 | grant1);
        in0    = '{addr: bus.addrInC0, data: bus.dataInC0, funct3: bus.funct3InC0};
        in1    = '{addr: bus.addrInC1, data: bus.dataInC1, funct3: bus.funct3InC1};
    end

    always_ff @(posedge clk) begin
        if (acc0) mem0[tail0] <= in0;
        if (acc1) mem1[tail1] <= in1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head0    <= '0;
            head1    <= '0;
            tail0    <= '0;
            tail1    <= '0;
            cnt0     <= '0;
            cnt1     <= '0;
            rr_ptr   <= 1'b0;
            out0     <= '0;
            out1     <= '0;
            wren0    <= 1'b0;
            wren1    <= 1'b0;
            coll_cnt <= '0;
        end else begin
            if (acc0)   tail0 <= tail0 + 1'b1;
            if (acc1)   tail1 <= tail1 + 1'b1;
            if (grant0) head0 <= head0 + 1'b1;
            if (grant1) head1 <= head1 + 1'b1;
            cnt0 <= cnt0 + CW'(acc0) - CW'(grant0);
            cnt1 <= cnt1 + CW'(acc1) - CW'(grant1);

            wren0 <= 1'b0;
            wren1 <= 1'b0;
            if (grant0) begin
                out1   <= mem0[head0];
                wren1  <= 1'b1;
                rr_ptr <= 1'b1;
            end else if (grant1) begin
                out0   <= mem1[head1];
                wren0  <= 1'b1;
                rr_ptr <= 1'b0;
            end

            if (vld0 && vld1 && (coll_cnt != {CNT_W{1'b1}}))
                coll_cnt <= coll_cnt + 1'b1;
        end
    end

    assign bus.wrenOutC0      = wren0;
    assign bus.addrOutC0      = out0.addr;
    assign bus.dataOutC0      = out0.data;
    assign bus.funct3OutC0    = out0.funct3;
    assign bus.wrenOutC1      = wren1;
    assign bus.addrOutC1      = out1.addr;
    assign bus.dataOutC1      = out1.data;
    assign bus.funct3OutC1    = out1.funct3;
    assign bus.extStall       = full0 | full1;
    assign bus.collisionCount = coll_cnt;
endmodule

// File: tb/tb_store_broadcast_arbiter.sv
// Drives two modelled cores that hold a store until it is accepted. Every cycle the DUT outputs
// are compared against a queue-based reference of the FIFO, round-robin and counter rules.
module tb_store_broadcast_arbiter;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct3;
    } st_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    store_broadcast_arbiter_if #(.CNT_W(CNT_W)) bus ();

    store_broadcast_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    st_t q0[$], q1[$];
    bit  rr;
    bit  e_wren0, e_wren1;
    st_t e_out0, e_out1;
    int  e_coll;
    bit  p0, p1;
    st_t s0, s1;
    int  a0 = 0, a1 = 0;
    bit  stall_seen;

    task automatic drive();
        bus.wrenInC0 = p0; bus.addrInC0 = s0.addr; bus.dataInC0 = s0.data; bus.funct3InC0 = s0.funct3;
        bus.wrenInC1 = p1; bus.addrInC1 = s1.addr; bus.dataInC1 = s1.data; bus.funct3InC1 = s1.funct3;
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        rr = 0; e_wren0 = 0; e_wren1 = 0; e_out0 = '0; e_out1 = '0; e_coll = 0;
        p0 = 0; p1 = 0;
    endtask

    // One clock edge: advance the model with the values on the inputs, then compare.
    task automatic step();
        bit v0, v1, g0, g1, f0, f1, ac0, ac1;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            v0 = q0.size() > 0;
            v1 = q1.size() > 0;
            g0 = v0 && (!v1 || !rr);
            g1 = v1 && !g0;
            f0 = q0.size() == DEPTH;
            f1 = q1.size() == DEPTH;
            ac0 = p0 && (!f0 || g0);
            ac1 = p1 && (!f1 || g1);
            if (v0 && v1 && e_coll < CMAX) e_coll++;
            e_wren0 = 0; e_wren1 = 0;
            if (g0) begin
                e_out1 = q0.pop_front(); e_wren1 = 1; rr = 1;
            end else if (g1) begin
                e_out0 = q1.pop_front(); e_wren0 = 1; rr = 0;
            end
            if (ac0) begin q0.push_back(s0); p0 = 0; end
            if (ac1) begin q1.push_back(s1); p1 = 0; end
        end
        #1;
        check_val("wrenOutC0",   32'(bus.wrenOutC0),   32'(e_wren0));
        check_val("wrenOutC1",   32'(bus.wrenOutC1),   32'(e_wren1));
        check_val("addrOutC0",   bus.addrOutC0,        e_out0.addr);
        check_val("dataOutC0",   bus.dataOutC0,        e_out0.data);
        check_val("funct3OutC0", 32'(bus.funct3OutC0), 32'(e_out0.funct3));
        check_val("addrOutC1",   bus.addrOutC1,        e_out1.addr);
        check_val("dataOutC1",   bus.dataOutC1,        e_out1.data);
        check_val("funct3OutC1", 32'(bus.funct3OutC1), 32'(e_out1.funct3));
        check_val("extStall",    32'(bus.extStall),
                  32'((q0.size() == DEPTH) || (q1.size() == DEPTH)));
        check_val("collisionCount", 32'(bus.collisionCount), 32'(e_coll));
        if (bus.extStall) stall_seen = 1;
        drive();
    endtask

    // Each idle core starts a new store with the given probability (percent).
    task automatic offer(input int rate);
        if (!p0 && $urandom_range(99) < rate) begin
            p0 = 1; a0++;
            s0 = '{addr: 32'h1000 + 32'(a0) * 4, data: $urandom, funct3: 3'($urandom_range(2))};
        end
        if (!p1 && $urandom_range(99) < rate) begin
            p1 = 1; a1++;
            s1 = '{addr: 32'h2000 + 32'(a1) * 4, data: $urandom, funct3: 3'($urandom_range(2))};
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
        drive();
    endtask

    initial begin
        model_reset();
        s0 = '0; s1 = '0;
        drive();
        do_reset();

        // Single store from core 0
        p0 = 1; s0 = '{addr: 32'h100, data: 32'hDEADBEEF, funct3: 3'b010};
        drive();
        step();
        step();
        check_val("single_wren1", 32'(bus.wrenOutC1), 32'd1);
        check_val("single_addr1", bus.addrOutC1, 32'h100);
        check_val("single_data1", bus.dataOutC1, 32'hDEADBEEF);
        check_val("single_wren0", 32'(bus.wrenOutC0), 32'd0);

        // Simultaneous stores
        do_reset();
        p0 = 1; s0 = '{addr: 32'h10, data: 32'h11, funct3: 3'b010};
        p1 = 1; s1 = '{addr: 32'h20, data: 32'h22, funct3: 3'b010};
        drive();
        step();
        step();
        check_val("simul_first_addr1", bus.addrOutC1, 32'h10);
        step();
        check_val("simul_second_wren0", 32'(bus.wrenOutC0), 32'd1);
        check_val("simul_second_addr0", bus.addrOutC0, 32'h20);
        check_val("simul_collisions", 32'(bus.collisionCount), 32'd1);

        // Back-to-back fill with both cores always requesting; one core-0 store is 0x40
        do_reset();
        stall_seen = 0;
        for (int i = 0; i < 12; i++) begin
            offer(100);
            if (i == 5 && p0) begin
                s0.addr = 32'h40;
                drive();
            end
            step();
        end
        check_val("fill_stall_seen", 32'(stall_seen), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            offer(i < 200 ? 60 : 25);
            step();
        end

        // Reset with both FIFOs holding stores, then idle
        for (int i = 0; i < 6; i++) begin
            offer(100);
            step();
        end
        check_val("pre_reset_depth0", 32'(q0.size()), 32'(DEPTH));
        do_reset();
        check_val("post_reset_stall", 32'(bus.extStall), 32'd0);
        check_val("post_reset_wren1", 32'(bus.wrenOutC1), 32'd0);
        for (int i = 0; i < 6; i++) step();

        // Collision counter saturation
        do_reset();
        for (int i = 0; i < 22; i++) begin
            offer(100);
            step();
        end
        check_val("coll_saturated", 32'(bus.collisionCount), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
